// File: rtl/spi_mem_pkg.sv
// Shared constants and FSM state type for the SPI memory initiator.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         FRAME_BITS = 48;
  localparam int         DATA_BITS  = 16;
  localparam int         ADDR_BITS  = 24;

  typedef enum logic [1:0] {IDLE, SHIFT, END, GAP} state_e;

endpackage

// File: rtl/spi_mem_initiator_spi_bit_engine.sv
// Mode-0 serialiser: two clk cycles per bit, MSB first, captures the last RX_BITS miso samples.
// done is asserted combinationally during the final high phase; rx_next carries the complete word then.
module spi_bit_engine
  import spi_mem_pkg::*;
#(
  parameter int N_BITS  = FRAME_BITS,
  parameter int RX_BITS = DATA_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_BITS-1:0]  tx_frame,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic               done,
  output logic [RX_BITS-1:0] rx_next
);

  localparam int            CW       = $clog2(N_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(N_BITS - 1);
  localparam logic [CW-1:0] FIRST_RX = CW'(N_BITS - RX_BITS);

  logic               active_q, active_d;
  logic               phase_q, phase_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [N_BITS-2:0]  shift_q, shift_d;
  logic [RX_BITS-2:0] rx_q, rx_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;

  assign done    = active_q & phase_q & (bit_cnt_q == LAST_BIT);
  assign rx_next = {rx_q, miso};
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

  always_comb begin
    active_d  = active_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    if (!active_q) begin
      if (start) begin
        active_d  = 1'b1;
        phase_d   = 1'b0;
        bit_cnt_d = '0;
        shift_d   = tx_frame[N_BITS-2:0];
        mosi_d    = tx_frame[N_BITS-1];
        sclk_d    = 1'b0;
      end
    end else if (!phase_q) begin
      phase_d = 1'b1;
      sclk_d  = 1'b1;
    end else begin
      // Falling edge of sclk: sample miso, then present the next bit.
      phase_d = 1'b0;
      sclk_d  = 1'b0;
      if (bit_cnt_q >= FIRST_RX) rx_d = rx_next[RX_BITS-2:0];
      if (done) begin
        active_d = 1'b0;
        mosi_d   = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        mosi_d    = shift_q[N_BITS-2];
        shift_d   = {shift_q[N_BITS-3:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

endmodule

// File: rtl/spi_mem_initiator.sv
// CPU-side SPI RAM master: one 16-bit read or write per request, cmd+addr+data frame MSB first.
// Accept-to-resp_valid is 96 edges; the next accept is possible DESELECT_CYCLES cycles after END.
module spi_mem_initiator
  import spi_mem_pkg::*;
#(
  parameter logic [7:0] READ_CMD        = CMD_READ,
  parameter logic [7:0] WRITE_CMD       = CMD_WRITE,
  parameter int         DESELECT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_rdata,
  output logic                 busy,
  output logic                 spi_select,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam logic [7:0] GAP_LAST = 8'(DESELECT_CYCLES > 1 ? DESELECT_CYCLES - 2 : 0);

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic                   select_q, select_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0]   resp_rdata_q, resp_rdata_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic                   accept;
  logic                   eng_done;
  logic [FRAME_BITS-1:0]  frame;
  logic [DATA_BITS-1:0]   eng_rx;

  assign accept = req_valid && (state_q == IDLE);
  assign frame  = {req_write ? WRITE_CMD : READ_CMD, req_addr,
                   req_write ? req_wdata : {DATA_BITS{1'b0}}};

  spi_bit_engine #(
    .N_BITS  (FRAME_BITS),
    .RX_BITS (DATA_BITS)
  ) u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .tx_frame (frame),
    .miso     (spi_miso),
    .sclk     (spi_clk),
    .mosi     (spi_mosi),
    .done     (eng_done),
    .rx_next  (eng_rx)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    gap_cnt_d    = gap_cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = 1'b0;
    select_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT;
          write_d  = req_write;
          select_d = 1'b1;
        end
      end
      SHIFT: begin
        // Select drops on the same edge that captures the final miso bit.
        if (eng_done) begin
          state_d      = END;
          resp_valid_d = 1'b1;
          if (!write_q) resp_rdata_d = eng_rx;
        end else begin
          select_d = 1'b1;
        end
      end
      END: begin
        gap_cnt_d = '0;
        state_d   = (DESELECT_CYCLES > 1) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      select_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      select_q     <= select_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign spi_select = select_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule
